// File: rtl/tortoise_pkg.sv
// Shared front-end types and sizing for the fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tortoise_pkg;

    localparam int unsigned INSTR_PER_FETCH   = 4;
    localparam int unsigned FETCH_QUEUE_DEPTH = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_compact.sv
// Packs the valid entries of a fetch group into the low indices and counts them.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the packed group is used.
module fetch_compact
    import tortoise_pkg::*;
#(
    parameter  int unsigned NR_INSTR = INSTR_PER_FETCH,
    localparam int unsigned CNT_W    = $clog2(NR_INSTR + 1)
) (
    input  fetch_entry_t     entries_i [NR_INSTR],
    output fetch_entry_t     compact_o [NR_INSTR],
    output logic [CNT_W-1:0] n_o
);

    localparam int unsigned IDX_W = (NR_INSTR > 1) ? $clog2(NR_INSTR) : 1;

    logic [CNT_W-1:0] cnt;

    // Walk the group in index order; each valid entry lands at the next free low slot.
    always_comb begin
        for (int unsigned i = 0; i < NR_INSTR; i++) begin
            compact_o[i] = '0;
        end
        cnt = '0;
        for (int unsigned i = 0; i < NR_INSTR; i++) begin
            if (entries_i[i].valid) begin
                compact_o[cnt[IDX_W-1:0]] = entries_i[i];
                cnt = cnt + CNT_W'(1);
            end
        end
        n_o = cnt;
    end

endmodule

// File: rtl/fetch_queue.sv
// Circular buffer between fetch and decode: compacts valid entries of each group, issues one per cycle.
// Latency: an entry pushed in cycle N is visible on instr_o in N+1 at the earliest (no bypass).
// Backpressure: fetch_ready_o needs a whole group of free slots (pops not credited); decode via valid/ready.
module fetch_queue
    import tortoise_pkg::*;
#(
    parameter int unsigned NR_INSTR = INSTR_PER_FETCH,
    parameter int unsigned DEPTH    = FETCH_QUEUE_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   fetch_valid_i,
    input  fetch_entry_t           fetch_instrs_i [NR_INSTR],
    output logic                   fetch_ready_o,
    output fetch_entry_t           instr_o,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned N_W   = $clog2(NR_INSTR + 1);

    if ((DEPTH < NR_INSTR) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_params
        $error("fetch_queue: DEPTH must be a power of two and at least NR_INSTR");
    end

    fetch_entry_t     mem [DEPTH];
    fetch_entry_t     compact [NR_INSTR];
    logic [N_W-1:0]   n;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    fetch_compact #(
        .NR_INSTR (NR_INSTR)
    ) u_compact (
        .entries_i (fetch_instrs_i),
        .compact_o (compact),
        .n_o       (n)
    );

    // Ready only looks at registered occupancy so fetch never depends on decode's ready.
    assign fetch_ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(NR_INSTR);
    assign instr_valid_o = (count_q != '0);
    assign count_o       = count_q;
    assign push          = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign pop           = instr_valid_o & instr_ready_i & ~flush_i;

    // Head entry straight from storage; stored valid bits are not trusted, so force it.
    always_comb begin
        instr_o = '0;
        if (instr_valid_o) begin
            instr_o       = mem[head_q];
            instr_o.valid = 1'b1;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over any handshake in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(pop);
            tail_q  <= tail_q + (push ? PTR_W'(n) : '0);
            count_q <= count_q + (push ? CNT_W'(n) : '0) - CNT_W'(pop);
        end
    end

    // Storage write: packed entry k goes to slot tail+k, wrapping through the pointer width.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < NR_INSTR; k++) begin
            if (push && (N_W'(k) < n)) begin
                mem[tail_q + PTR_W'(k)] <= compact[k];
            end
        end
    end

    count_le_depth: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table of per-cycle stimulus and expected outputs for fetch_queue, plus reset sequences.
// Latency: outputs compared #1 after the falling edge, before the next rising edge.
// Backpressure: exercised through instr_ready_i patterns and full-queue rows.
module tb_fetch_queue;
    import tortoise_pkg::*;

    localparam int unsigned NR    = INSTR_PER_FETCH;
    localparam int unsigned DEPTH = FETCH_QUEUE_DEPTH;

    typedef struct {
        logic        fl;
        logic        fv;
        logic [3:0]  mask;
        logic [31:0] base;
        logic        rdy;
        int          cnt;
        logic        vld;
        logic [31:0] addr;
        logic        frdy;
    } vec_t;

    logic                   clk;
    logic                   rst_n;
    logic                   flush;
    logic                   fetch_valid;
    fetch_entry_t           fetch_instrs [NR];
    logic                   fetch_ready;
    fetch_entry_t           instr;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [$clog2(DEPTH):0] count;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];

    fetch_queue #(
        .NR_INSTR (NR),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .fetch_valid_i  (fetch_valid),
        .fetch_instrs_i (fetch_instrs),
        .fetch_ready_o  (fetch_ready),
        .instr_o        (instr),
        .instr_valid_o  (instr_valid),
        .instr_ready_i  (instr_ready),
        .count_o        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic fl, input logic fv, input logic [3:0] mask,
                                input logic [31:0] base, input logic rdy, input int cnt,
                                input logic vld, input logic [31:0] addr, input logic frdy);
        vec_t v;
        v.fl = fl; v.fv = fv; v.mask = mask; v.base = base; v.rdy = rdy;
        v.cnt = cnt; v.vld = vld; v.addr = addr; v.frdy = frdy;
        return v;
    endfunction

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0000;
    endfunction

    task automatic drive(input logic fl, input logic fv, input logic [3:0] mask,
                         input logic [31:0] base, input logic rdy);
        flush       = fl;
        fetch_valid = fv;
        instr_ready = rdy;
        for (int i = 0; i < NR; i++) begin
            fetch_instrs[i].valid = mask[i];
            fetch_instrs[i].addr  = base + 32'(4 * i);
            fetch_instrs[i].instr = instr_of(base + 32'(4 * i));
        end
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, got, exp);
        end
    endtask

    initial begin
        // Reset then one full group drained with ready held high
        vecs.push_back(mk(0, 1, 4'hF, 32'h100, 1, 0, 0, 32'h000, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 4, 1, 32'h100, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 3, 1, 32'h104, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 2, 1, 32'h108, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 1, 1, 32'h10C, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 0, 0, 0, 32'h000, 1));
        // Prefix mask, then sparse mask, then an empty group accepted alongside a pop
        vecs.push_back(mk(0, 1, 4'h3, 32'h200, 0, 0, 0, 32'h000, 1));
        vecs.push_back(mk(0, 1, 4'hA, 32'h300, 0, 2, 1, 32'h200, 1));
        vecs.push_back(mk(0, 1, 4'h0, 32'h400, 1, 4, 1, 32'h200, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 3, 1, 32'h204, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 2, 1, 32'h304, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 1, 1, 32'h30C, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 0, 0, 0, 32'h000, 1));
        // Push+pop together reaching count 5, then flush with push and pop requested
        vecs.push_back(mk(0, 1, 4'hF, 32'h500, 0, 0, 0, 32'h000, 1));
        vecs.push_back(mk(0, 1, 4'h3, 32'h600, 1, 4, 1, 32'h500, 1));
        vecs.push_back(mk(1, 1, 4'hF, 32'h700, 1, 5, 1, 32'h504, 0));
        vecs.push_back(mk(0, 1, 4'hF, 32'h800, 0, 0, 0, 32'h000, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 4, 1, 32'h800, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 3, 1, 32'h804, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 2, 1, 32'h808, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 1, 1, 32'h80C, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 0, 0, 0, 32'h000, 1));
        // Tail at 6: three-entry push with a pop at count 2 wraps into slot 0
        vecs.push_back(mk(0, 1, 4'h3, 32'h900, 0, 0, 0, 32'h000, 1));
        vecs.push_back(mk(0, 1, 4'h7, 32'hA00, 1, 2, 1, 32'h900, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 4, 1, 32'h904, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 3, 1, 32'hA00, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 2, 1, 32'hA04, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 1, 1, 32'hA08, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 0, 0, 0, 32'h000, 1));
        // Fill to DEPTH, hold a third group off, pop without crediting ready, drain
        vecs.push_back(mk(0, 1, 4'hF, 32'hB00, 0, 0, 0, 32'h000, 1));
        vecs.push_back(mk(0, 1, 4'hF, 32'hC00, 0, 4, 1, 32'hB00, 1));
        vecs.push_back(mk(0, 1, 4'hF, 32'hD00, 0, 8, 1, 32'hB00, 0));
        vecs.push_back(mk(0, 1, 4'hF, 32'hD00, 1, 8, 1, 32'hB00, 0));
        vecs.push_back(mk(0, 1, 4'hF, 32'hD00, 0, 7, 1, 32'hB04, 0));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 7, 1, 32'hB04, 0));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 6, 1, 32'hB08, 0));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 5, 1, 32'hB0C, 0));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 4, 1, 32'hC00, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 3, 1, 32'hC04, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 2, 1, 32'hC08, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 1, 1, 1, 32'hC0C, 1));
        vecs.push_back(mk(0, 0, 4'h0, 32'h000, 0, 0, 0, 32'h000, 1));

        rst_n = 1'b0;
        drive(0, 0, 4'h0, 32'h0, 0);
        #2;
        chk("reset_count", -1, 32'(count), 32'd0);
        chk("reset_valid", -1, 32'(instr_valid), 32'd0);
        chk("reset_instr", -1, instr.addr | instr.instr | 32'(instr.valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_fetch_ready", -1, 32'(fetch_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].fl, vecs[i].fv, vecs[i].mask, vecs[i].base, vecs[i].rdy);
            #1;
            chk("count", i, 32'(count), 32'(vecs[i].cnt));
            chk("instr_valid", i, 32'(instr_valid), 32'(vecs[i].vld));
            chk("instr_entry_valid", i, 32'(instr.valid), 32'(vecs[i].vld));
            chk("instr_addr", i, instr.addr, vecs[i].vld ? vecs[i].addr : 32'h0);
            chk("instr_word", i, instr.instr, vecs[i].vld ? instr_of(vecs[i].addr) : 32'h0);
            chk("fetch_ready", i, 32'(fetch_ready), 32'(vecs[i].frdy));
        end

        // Asynchronous reset in the middle of operation drops buffered entries at once
        @(negedge clk);
        drive(0, 1, 4'hF, 32'hE00, 0);
        @(negedge clk);
        drive(0, 0, 4'h0, 32'h0, 0);
        #1;
        chk("midrst_pre_count", 100, 32'(count), 32'd4);
        chk("midrst_pre_addr", 100, instr.addr, 32'hE00);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 101, 32'(count), 32'd0);
        chk("midrst_valid", 101, 32'(instr_valid), 32'd0);
        chk("midrst_instr", 101, instr.addr | instr.instr | 32'(instr.valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 4'h6, 32'hF00, 0);
        #1;
        chk("postrst_fetch_ready", 102, 32'(fetch_ready), 32'd1);
        @(negedge clk);
        drive(0, 0, 4'h0, 32'h0, 1);
        #1;
        chk("postrst_count", 103, 32'(count), 32'd2);
        chk("postrst_addr", 103, instr.addr, 32'hF04);
        @(negedge clk);
        drive(0, 0, 4'h0, 32'h0, 1);
        #1;
        chk("postrst_addr2", 104, instr.addr, 32'hF08);
        @(negedge clk);
        drive(0, 0, 4'h0, 32'h0, 0);
        #1;
        chk("postrst_empty", 105, 32'(instr_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
